// File: rtl/mat_pkg.sv
// Shared constants, kernel geometry and types for the 27-tap diamond fetch path.
package mat_pkg;

    localparam int MAT_TAPS  = 27;
    localparam int MAT_IMG_W = 180;
    localparam int MAT_IMG_H = 120;
    localparam int MAT_IDX_W = 5;

    // Diamond kernel offsets by tap index; tap 0 is the reference pixel itself.
    localparam logic signed [3:0] TAP_DX [MAT_TAPS] = '{
        4'sd0,  4'sd0,
        -4'sd1, 4'sd0,  4'sd1,
        -4'sd2, -4'sd1, 4'sd0,  4'sd1,  4'sd2,
        -4'sd4, -4'sd3, -4'sd2, -4'sd1,
        4'sd1,  4'sd2,  4'sd3,  4'sd4,
        -4'sd2, -4'sd1, 4'sd0,  4'sd1,  4'sd2,
        -4'sd1, 4'sd0,  4'sd1,
        4'sd0
    };

    localparam logic signed [3:0] TAP_DY [MAT_TAPS] = '{
        4'sd0,  -4'sd3,
        -4'sd2, -4'sd2, -4'sd2,
        -4'sd1, -4'sd1, -4'sd1, -4'sd1, -4'sd1,
        4'sd0,  4'sd0,  4'sd0,  4'sd0,
        4'sd0,  4'sd0,  4'sd0,  4'sd0,
        4'sd1,  4'sd1,  4'sd1,  4'sd1,  4'sd1,
        4'sd2,  4'sd2,  4'sd2,
        4'sd3
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } matState_t;

    typedef struct packed {
        logic                 valid;
        logic                 inb;
        logic [MAT_IDX_W-1:0] idx;
    } matPipe_t;

endpackage

// File: rtl/mat_rd_pipe.sv
// Tap metadata delay line that tracks each issued tap until its SRAM data returns.
module mat_rd_pipe
    import mat_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     resetn,
    input  matPipe_t pipeIn,
    output matPipe_t pipeOut
);

    matPipe_t stage [DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= pipeIn;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign pipeOut = stage[DEPTH-1];

endmodule

// File: rtl/mat_tap_fetch.sv
// Walks the 27 kernel taps around a reference pixel, reads in-bounds taps from
// the frame-buffer SRAM and writes every tap (zero when off-image) in index order.
module mat_tap_fetch
    import mat_pkg::*;
#(
    parameter int IMG_W  = MAT_IMG_W,
    parameter int IMG_H  = MAT_IMG_H,
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        ref_x,
    input  logic [6:0]        ref_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_rd,
    input  logic [DATA_W-1:0] sram_data,
    output logic              tap_we,
    output logic [4:0]        tap_idx,
    output logic [DATA_W-1:0] tap_data,
    output matState_t         dbgState
);

    // Request handshake: start is a single-cycle request that is taken only
    // while the FSM sits in ST_IDLE (busy=0, done=0); any other start is dropped.
    // The request completes with exactly 27 tap_we beats and one done pulse.

    localparam logic [ADDR_W-1:0]   IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic signed [10:0]  IMG_W_S  = 11'(IMG_W);
    localparam logic signed [9:0]   IMG_W_P  = 10'(IMG_W);
    localparam logic signed [9:0]   IMG_H_P  = 10'(IMG_H);
    localparam logic [4:0]          LAST_TAP = 5'(MAT_TAPS - 1);
    localparam logic [2:0]          DRAIN_LAST = 3'(RD_LAT);

    matState_t state, nextState;
    logic [4:0]  tapK, tapKNext;
    logic [2:0]  drainCnt, drainCntNext;
    logic        issue;
    logic [4:0]  issueIdx;

    logic [7:0]        refXQ, curX;
    logic [6:0]        refYQ, curY;
    logic [ADDR_W-1:0] baseQ, curBase, tapAddr;
    logic signed [3:0] dx, dy;
    logic signed [10:0] dxSx, dySx, tapOff;
    logic signed [9:0] posX, posY;
    logic              refOk, tapInb;

    matPipe_t pipeIn, pipeOut;

    always_comb begin
        nextState    = state;
        tapKNext     = tapK;
        drainCntNext = drainCnt;
        issue        = 1'b0;
        issueIdx     = '0;
        case (state)
            ST_IDLE: begin
                // Tap 0 is launched on the accepting edge so reads start the next cycle.
                if (start) begin
                    nextState = ST_ISSUE;
                    tapKNext  = 5'd1;
                    issue     = 1'b1;
                end
            end
            ST_ISSUE: begin
                issue    = 1'b1;
                issueIdx = tapK;
                tapKNext = tapK + 5'd1;
                if (tapK == LAST_TAP) begin
                    nextState    = ST_DRAIN;
                    drainCntNext = '0;
                end
            end
            ST_DRAIN: begin
                if (drainCnt == DRAIN_LAST) begin
                    nextState = ST_DONE;
                end else begin
                    drainCntNext = drainCnt + 3'd1;
                end
            end
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // In IDLE the geometry is taken straight from the request so tap 0 needs no extra cycle.
    always_comb begin
        curX    = (state == ST_IDLE) ? ref_x : refXQ;
        curY    = (state == ST_IDLE) ? ref_y : refYQ;
        curBase = (state == ST_IDLE) ? (ADDR_W'(ref_y) * IMG_W_A + ADDR_W'(ref_x)) : baseQ;
        dx      = TAP_DX[issueIdx];
        dy      = TAP_DY[issueIdx];
        dxSx    = 11'(dx);
        dySx    = 11'(dy);
        tapOff  = dySx * IMG_W_S + dxSx;
        tapAddr = curBase + ADDR_W'(tapOff);
        posX    = $signed({2'b00, curX}) + 10'(dx);
        posY    = $signed({3'b000, curY}) + 10'(dy);
        refOk   = ($signed({2'b00, curX}) < IMG_W_P) && ($signed({3'b000, curY}) < IMG_H_P);
        tapInb  = refOk && (posX >= 10'sd0) && (posX < IMG_W_P)
                        && (posY >= 10'sd0) && (posY < IMG_H_P);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            tapK      <= '0;
            drainCnt  <= '0;
            refXQ     <= '0;
            refYQ     <= '0;
            baseQ     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sram_rd   <= 1'b0;
            sram_addr <= '0;
        end else begin
            state    <= nextState;
            tapK     <= tapKNext;
            drainCnt <= drainCntNext;
            if (state == ST_IDLE && start) begin
                refXQ <= ref_x;
                refYQ <= ref_y;
                baseQ <= curBase;
            end
            busy    <= (nextState == ST_ISSUE) || (nextState == ST_DRAIN);
            done    <= (nextState == ST_DONE);
            sram_rd <= issue && tapInb;
            if (issue && tapInb) begin
                sram_addr <= tapAddr;
            end
        end
    end

    assign pipeIn = '{valid: issue, inb: tapInb, idx: issueIdx};

    mat_rd_pipe #(
        .DEPTH (RD_LAT)
    ) uPipe (
        .clk     (clk),
        .resetn  (resetn),
        .pipeIn  (pipeIn),
        .pipeOut (pipeOut)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tap_we   <= 1'b0;
            tap_idx  <= '0;
            tap_data <= '0;
        end else begin
            tap_we <= pipeOut.valid;
            if (pipeOut.valid) begin
                tap_idx  <= pipeOut.idx;
                tap_data <= pipeOut.inb ? sram_data : '0;
            end
        end
    end

    assign dbgState = state;

endmodule

// File: tb/tb_mat_tap_fetch.sv
// Bench for mat_tap_fetch: three builds (RD_LAT 1, 2, 4) share one stimulus stream,
// each with its own SRAM model and event recorder.
module tb_mat_tap_fetch;
    import mat_pkg::*;

    localparam int TB_DX [27] = '{0, 0, -1, 0, 1, -2, -1, 0, 1, 2, -4, -3, -2, -1,
                                  1, 2, 3, 4, -2, -1, 0, 1, 2, -1, 0, 1, 0};
    localparam int TB_DY [27] = '{0, -3, -2, -2, -2, -1, -1, -1, -1, -1, 0, 0, 0, 0,
                                  0, 0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] refX;
    logic [6:0] refY;
    logic       recClr;
    int         cyc;
    int         startCyc;
    int         total;
    int         bad;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT builds, SRAM models, recorders ----------------
    for (genvar g = 0; g < 3; g++) begin : gLat
        localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

        logic        busy, done, sramRd, tapWe;
        logic [14:0] sramAddr;
        logic [15:0] sramData, tapData, rawData;
        logic [4:0]  tapIdx;
        matState_t   dbgState;
        logic [15:0] dly [4];

        int          wrCnt, orderBad, doneCnt, doneRel, rdCnt;
        int          busyCnt, busyFirst, busyLast, rel;
        logic [15:0] wrData [27];
        int          wrRel  [27];
        int          rdAddr [27];
        logic [26:0] rdSeen;

        mat_tap_fetch #(.RD_LAT(L)) dut (
            .clk       (clk),
            .resetn    (resetn),
            .start     (start),
            .ref_x     (refX),
            .ref_y     (refY),
            .busy      (busy),
            .done      (done),
            .sram_addr (sramAddr),
            .sram_rd   (sramRd),
            .sram_data (sramData),
            .tap_we    (tapWe),
            .tap_idx   (tapIdx),
            .tap_data  (tapData),
            .dbgState  (dbgState)
        );

        // Data for a strobe launched at edge e is what the DUT samples at edge e+L;
        // non-read cycles return a poison word so misaligned capture shows up.
        assign rawData = sramRd ? (16'(sramAddr) ^ 16'h5A5A) : 16'hDEAD;

        always @(posedge clk) begin
            dly[0] <= rawData;
            for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
        end

        if (L == 1) begin : gComb
            assign sramData = rawData;
        end else begin : gDly
            assign sramData = dly[L-2];
        end

        initial begin
            forever begin
                @(negedge clk);
                rel = cyc - startCyc;
                if (recClr) begin
                    wrCnt = 0; orderBad = 0; doneCnt = 0; doneRel = -1; rdCnt = 0;
                    busyCnt = 0; busyFirst = -1; busyLast = -1; rdSeen = '0;
                    for (int k = 0; k < 27; k++) begin
                        wrData[k] = 16'hBEEF;
                        wrRel[k]  = -1;
                        rdAddr[k] = -1;
                    end
                end else begin
                    if (tapWe) begin
                        if (int'(tapIdx) != (wrCnt % 27)) orderBad++;
                        if (tapIdx < 5'd27) begin
                            wrData[tapIdx] = tapData;
                            wrRel[tapIdx]  = rel;
                        end
                        wrCnt++;
                    end
                    if (sramRd) begin
                        rdCnt++;
                        if (rel >= 1 && rel <= 27) begin
                            rdSeen[rel-1] = 1'b1;
                            rdAddr[rel-1] = int'(sramAddr);
                        end
                    end
                    if (done) begin
                        doneCnt++;
                        doneRel = rel;
                    end
                    if (busy) begin
                        if (busyCnt == 0) busyFirst = rel;
                        busyLast = rel;
                        busyCnt++;
                    end
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic checkVal(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic verifyRun(input string tag, input int lat, input int x, input int y,
                             input int wrCnt, input int orderBad, input int doneCnt,
                             input int doneRel, input logic [15:0] wrData [27],
                             input int wrRel [27], input int rdAddr [27],
                             input logic [26:0] rdSeen);
        int          ex, ey, ea;
        logic        inb;
        logic [15:0] ed;
        string       t;
        t = $sformatf("%s_L%0d", tag, lat);
        checkVal({t, "_wrcnt"}, wrCnt, 27);
        checkVal({t, "_order"}, orderBad, 0);
        checkVal({t, "_donecnt"}, doneCnt, 1);
        checkVal({t, "_donecyc"}, doneRel, 28 + lat);
        for (int k = 0; k < 27; k++) begin
            ex  = x + TB_DX[k];
            ey  = y + TB_DY[k];
            inb = (ex >= 0) && (ex < 180) && (ey >= 0) && (ey < 120);
            ea  = (ey * 180 + ex) & 32'h7FFF;
            ed  = inb ? (16'(ea) ^ 16'h5A5A) : 16'h0000;
            checkVal($sformatf("%s_data%0d", t, k), wrData[k], ed);
            checkVal($sformatf("%s_wcyc%0d", t, k), wrRel[k], 1 + k + lat);
            checkVal($sformatf("%s_rd%0d", t, k), rdSeen[k], inb);
            if (inb) checkVal($sformatf("%s_addr%0d", t, k), rdAddr[k], ea);
        end
    endtask

    task automatic verifyAll(input string tag, input int x, input int y);
        verifyRun(tag, 1, x, y, gLat[0].wrCnt, gLat[0].orderBad, gLat[0].doneCnt,
                  gLat[0].doneRel, gLat[0].wrData, gLat[0].wrRel, gLat[0].rdAddr, gLat[0].rdSeen);
        verifyRun(tag, 2, x, y, gLat[1].wrCnt, gLat[1].orderBad, gLat[1].doneCnt,
                  gLat[1].doneRel, gLat[1].wrData, gLat[1].wrRel, gLat[1].rdAddr, gLat[1].rdSeen);
        verifyRun(tag, 4, x, y, gLat[2].wrCnt, gLat[2].orderBad, gLat[2].doneCnt,
                  gLat[2].doneRel, gLat[2].wrData, gLat[2].wrRel, gLat[2].rdAddr, gLat[2].rdSeen);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulseStart(input int x, input int y);
        start    = 1'b1;
        refX     = 8'(x);
        refY     = 7'(y);
        startCyc = cyc;
        recClr   = 1'b1;
        @(posedge clk); #2;
        start  = 1'b0;
        recClr = 1'b0;
    endtask

    task automatic pokeStart();
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic waitRel(input int r);
        while (cyc < startCyc + r) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic resetPulse();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        total = 0; bad = 0; cyc = 0; startCyc = 0;
        start = 1'b0; refX = '0; refY = '0; recClr = 1'b0; resetn = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkVal("rst_busy",   gLat[1].busy, 0);
        checkVal("rst_done",   gLat[1].done, 0);
        checkVal("rst_rd",     gLat[1].sramRd, 0);
        checkVal("rst_addr",   gLat[1].sramAddr, 0);
        checkVal("rst_we",     gLat[1].tapWe, 0);
        checkVal("rst_idx",    gLat[1].tapIdx, 0);
        checkVal("rst_data",   gLat[1].tapData, 0);
        checkVal("rst_state",  gLat[1].dbgState, ST_IDLE);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(posedge clk); #2;

        // centre of the image: every tap readable
        pulseStart(90, 60);
        waitRel(36);
        verifyAll("c90", 90, 60);
        checkVal("c90_rdcnt", gLat[1].rdCnt, 27);
        checkVal("c90_a0",    gLat[1].rdAddr[0], 10890);
        checkVal("c90_a1",    gLat[1].rdAddr[1], 10350);
        checkVal("c90_a26",   gLat[1].rdAddr[26], 11430);
        checkVal("c90_a10",   gLat[1].rdAddr[10], 10886);
        checkVal("c90_done",  gLat[1].doneRel, 30);
        checkVal("c90_bfirst", gLat[1].busyFirst, 1);
        checkVal("c90_blast", gLat[1].busyLast, 29);
        checkVal("c90_bcnt",  gLat[1].busyCnt, 29);

        // top-left corner
        pulseStart(0, 0);
        waitRel(36);
        verifyAll("c00", 0, 0);
        checkVal("c00_rdcnt", gLat[1].rdCnt, 11);
        checkVal("c00_d20",   gLat[1].wrData[20], 16'h5AEE);
        checkVal("c00_d1",    gLat[1].wrData[1], 0);

        // bottom-right corner
        pulseStart(179, 119);
        waitRel(36);
        verifyAll("cbr", 179, 119);
        checkVal("cbr_rdcnt", gLat[1].rdCnt, 11);
        checkVal("cbr_a0",    gLat[1].rdAddr[0], 21599);
        checkVal("cbr_d26",   gLat[1].wrData[26], 0);

        // starts while busy and in the done cycle are dropped; the next one is taken
        pulseStart(90, 60);
        waitRel(5);
        pokeStart();
        waitRel(30);
        pokeStart();
        pokeStart();
        waitRel(66);
        checkVal("b2b_donecnt", gLat[1].doneCnt, 2);
        checkVal("b2b_donecyc", gLat[1].doneRel, 61);
        checkVal("b2b_wrcnt",   gLat[1].wrCnt, 54);
        checkVal("b2b_order",   gLat[1].orderBad, 0);
        checkVal("b2b_rdcnt",   gLat[1].rdCnt, 54);

        resetPulse();
        @(posedge clk); #2;

        // reset in the middle of a request
        pulseStart(90, 60);
        waitRel(12);
        resetn = 1'b0;
        #1;
        checkVal("mid_busy",  gLat[1].busy, 0);
        checkVal("mid_rd",    gLat[1].sramRd, 0);
        checkVal("mid_addr",  gLat[1].sramAddr, 0);
        checkVal("mid_we",    gLat[1].tapWe, 0);
        checkVal("mid_state", gLat[1].dbgState, ST_IDLE);
        repeat (2) @(posedge clk);
        #2;
        resetn = 1'b1;
        waitRel(50);
        checkVal("mid_wr_L1",   gLat[0].wrCnt, 10);
        checkVal("mid_wr_L2",   gLat[1].wrCnt, 9);
        checkVal("mid_wr_L4",   gLat[2].wrCnt, 7);
        checkVal("mid_done_L1", gLat[0].doneCnt, 0);
        checkVal("mid_done_L2", gLat[1].doneCnt, 0);
        checkVal("mid_done_L4", gLat[2].doneCnt, 0);

        pulseStart(90, 60);
        waitRel(36);
        verifyAll("post", 90, 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
